alu_multicycle_seq: RTL and testbench

- Parametrised, handshaked multicycle successor to the combinational vector ALU.
- Accepts one operation per transaction and performs lane-wise add/sub over byte, halfword, word or doubleword lanes.
- Performs lane-wise even/odd unsigned widening multiply using an iterative shift-add engine.
- Holds each result until the consumer takes it; sits between operand read and writeback in the vector datapath.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_iter_mul.sv | 104 ++++++++++
 rtl/alu_multicycle_seq.sv | 145 ++++++++++++++
 tb/tb_alu_multicycle_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multicycle vector ALU: opcode encodings, lane
// width encodings, the controller state type and helpers that turn a ww code
// into a bit width.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [5:0] ALU_ADD  = 6'b000101;
    localparam logic [5:0] ALU_SUB  = 6'b000110;
    localparam logic [5:0] ALU_MULE = 6'b001000;
    localparam logic [5:0] ALU_MULO = 6'b000111;

    localparam logic [1:0] WW_B = 2'b00;
    localparam logic [1:0] WW_H = 2'b01;
    localparam logic [1:0] WW_W = 2'b10;
    localparam logic [1:0] WW_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Add/sub lane width in bits for a given ww code.
    function automatic int lane_width(input logic [1:0] ww);
        case (ww)
            WW_B:    return 8;
            WW_H:    return 16;
            WW_W:    return 32;
            default: return 64;
        endcase
    endfunction

    // Multiply source element width in bits; the doubleword code has no
    // multiply form and maps to zero.
    function automatic int elem_width(input logic [1:0] ww);
        case (ww)
            WW_B:    return 8;
            WW_H:    return 16;
            WW_W:    return 32;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/alu_iter_mul.sv
// ---------------------------------------------------------------------------
// alu_iter_mul
// Lane-wise unsigned widening multiplier built as a shift-add engine that
// retires one multiplier bit per clock in every lane at once.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           load operands and begin a new multiply
//   ww              source element width code (00 byte, 01 half, 10 word)
//   mode            0: even elements (low half of each lane)
//                   1: odd elements (high half of each lane)
//   opr_a, opr_b    full-width operands, bit 0 is the MSB
//   done            high during the cycle the final step is applied
//   product         accumulator value that the current step produces;
//                   holds the finished result while done is high
// ---------------------------------------------------------------------------
module alu_iter_mul
    import alu_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    ww,
    input  logic          mode,
    input  logic [0:DW-1] opr_a,
    input  logic [0:DW-1] opr_b,
    output logic          done,
    output logic [0:DW-1] product
);

    logic [DW-1:0] a_src;
    logic [DW-1:0] b_src;
    logic [DW-1:0] a_sh;
    logic [DW-1:0] b_sh;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;
    logic [DW-1:0] lane_fill;
    logic [1:0]    ww_q;
    logic [5:0]    cnt;

    // Mask selecting the low half of every 2W-bit lane.
    function automatic logic [DW-1:0] half_mask(input logic [1:0] w);
        case (w)
            WW_B:    return {(DW/16){16'h00FF}};
            WW_H:    return {(DW/32){32'h0000_FFFF}};
            default: return {(DW/64){64'h0000_0000_FFFF_FFFF}};
        endcase
    endfunction

    // Bring the selected element of each lane down into the lane's low half
    // so both even and odd forms run through the same engine.
    always_comb begin
        a_src = opr_a;
        b_src = opr_b;
        if (mode) begin
            a_src = opr_a >> elem_width(ww);
            b_src = opr_b >> elem_width(ww);
        end
    end

    // Each lane's multiplier LSB gates the shifted multiplicand for that
    // lane. Partial sums never exceed 2W bits, so one full-width add cannot
    // carry between lanes.
    always_comb begin
        lane_fill = '0;
        for (int p = 0; p < DW; p++) begin
            case (ww_q)
                WW_B:    lane_fill[p] = b_sh[(p / 16) * 16];
                WW_H:    lane_fill[p] = b_sh[(p / 32) * 32];
                default: lane_fill[p] = b_sh[(p / 64) * 64];
            endcase
        end
        acc_next = acc + (a_sh & lane_fill);
    end

    assign done    = (cnt == 6'd1);
    assign product = acc_next;

    // The multiplicand shifts up inside its lane, and the multiplier shifts
    // down with its low-half mask so neighbouring lanes do not leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            ww_q <= WW_B;
            cnt  <= '0;
        end else if (start) begin
            a_sh <= a_src & half_mask(ww);
            b_sh <= b_src & half_mask(ww);
            acc  <= '0;
            ww_q <= ww;
            cnt  <= 6'(elem_width(ww));
        end else if (cnt != 6'd0) begin
            a_sh <= a_sh << 1;
            b_sh <= (b_sh >> 1) & half_mask(ww_q);
            acc  <= acc_next;
            cnt  <= cnt - 6'd1;
        end
    end

endmodule

// File: rtl/alu_multicycle_seq.sv
// ---------------------------------------------------------------------------
// alu_multicycle_seq
// Handshaked vector ALU. Lane-wise add/sub finishes in one cycle. Even/odd
// widening multiply runs on an iterative shift-add engine. Each result is
// held until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   operation handshake; in_ready is high only in IDLE
//   alu_op                opcode (ADD, SUB, MULE, MULO; others are illegal)
//   ww                    lane width code
//   opr_a, opr_b          operands, bit 0 is the MSB
//   out_valid / out_ready result handshake
//   dout                  result, stable while out_valid is high
//   err                   result came from an illegal opcode/ww pair
// ---------------------------------------------------------------------------
module alu_multicycle_seq
    import alu_pkg::*;
#(
    parameter int DW  = 64,
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] alu_op,
    input  logic [1:0]     ww,
    input  logic [0:DW-1]  opr_a,
    input  logic [0:DW-1]  opr_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [0:DW-1]  dout,
    output logic           err
);

    state_t        state;
    logic          is_add;
    logic          is_sub;
    logic          is_mule;
    logic          is_mulo;
    logic          mul_ok;
    logic          mul_start;
    logic          mul_done;
    logic [0:DW-1] mul_product;
    logic [DW-1:0] a_v;
    logic [DW-1:0] b_v;
    logic [DW-1:0] addsub_res;
    logic [8:0]    byte_sum;
    logic          carry;
    int            lane_bytes;

    assign is_add    = (alu_op == OPW'(ALU_ADD));
    assign is_sub    = (alu_op == OPW'(ALU_SUB));
    assign is_mule   = (alu_op == OPW'(ALU_MULE));
    assign is_mulo   = (alu_op == OPW'(ALU_MULO));
    assign mul_ok    = (is_mule || is_mulo) && (ww != WW_D);
    assign mul_start = (state == IDLE) && in_valid && in_ready && mul_ok;

    // Byte-sliced ripple add. The carry chain restarts at every lane
    // boundary, with a carry-in of one for subtraction (a + ~b + 1).
    always_comb begin
        addsub_res = '0;
        a_v        = opr_a;
        b_v        = is_sub ? ~opr_b : opr_b;
        lane_bytes = lane_width(ww) / 8;
        carry      = is_sub;
        byte_sum   = '0;
        for (int j = 0; j < DW / 8; j++) begin
            if ((j & (lane_bytes - 1)) == 0) begin
                carry = is_sub;
            end
            byte_sum = {1'b0, a_v[j*8 +: 8]} + {1'b0, b_v[j*8 +: 8]} + {8'd0, carry};
            addsub_res[j*8 +: 8] = byte_sum[7:0];
            carry = byte_sum[8];
        end
    end

    alu_iter_mul #(
        .DW (DW)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .ww      (ww),
        .mode    (is_mulo),
        .opr_a   (opr_a),
        .opr_b   (opr_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Controller and output register. Add/sub and illegal requests go
    // straight to DONE on the accept edge. A multiply waits in BUSY until the
    // engine's last step, then captures the product on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dout      <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (is_add || is_sub) begin
                            dout      <= addsub_res;
                            err       <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else if (mul_ok) begin
                            state <= BUSY;
                        end else begin
                            dout      <= '0;
                            err       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                BUSY: begin
                    if (mul_done) begin
                        dout      <= mul_product;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_multicycle_seq
// Self-checking bench for alu_multicycle_seq: directed vectors, a mid-multiply
// reset, and randomized operations compared against a lane-level arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_alu_multicycle_seq;

    localparam int DW = 64;
    localparam logic [5:0] OP_ADD  = 6'b000101;
    localparam logic [5:0] OP_SUB  = 6'b000110;
    localparam logic [5:0] OP_MULE = 6'b001000;
    localparam logic [5:0] OP_MULO = 6'b000111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [5:0]    alu_op;
    logic [1:0]    ww;
    logic [0:DW-1] opr_a;
    logic [0:DW-1] opr_b;
    logic          out_valid;
    logic          out_ready;
    logic [0:DW-1] dout;
    logic          err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_multicycle_seq #(
        .DW  (DW),
        .OPW (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .ww        (ww),
        .opr_a     (opr_a),
        .opr_b     (opr_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .err       (err)
    );

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Reference model: slices operands into lanes and applies plain integer
    // arithmetic per lane.
    function automatic void refModel(input logic [5:0] op, input logic [1:0] w,
                                     input logic [63:0] a, input logic [63:0] b,
                                     output logic [63:0] d, output logic e, output int lat);
        int          lw;
        int          ew;
        logic [63:0] m;
        logic [63:0] mw;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] r;
        d   = '0;
        e   = 1'b0;
        lat = 1;
        if (op == OP_ADD || op == OP_SUB) begin
            lw = 8 << w;
            m  = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
            for (int k = 0; k < 64 / lw; k++) begin
                x = (a >> (k * lw)) & m;
                y = (b >> (k * lw)) & m;
                r = (op == OP_ADD) ? x + y : x - y;
                d = d | ((r & m) << (k * lw));
            end
        end else if ((op == OP_MULE || op == OP_MULO) && w != 2'b11) begin
            ew  = 8 << w;
            lw  = 2 * ew;
            lat = ew + 1;
            m   = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
            mw  = (64'd1 << ew) - 64'd1;
            for (int k = 0; k < 64 / lw; k++) begin
                x = (a >> (k * lw)) & m;
                y = (b >> (k * lw)) & m;
                x = (op == OP_MULE) ? (x & mw) : (x >> ew);
                y = (op == OP_MULE) ? (y & mw) : (y >> ew);
                r = x * y;
                d = d | ((r & m) << (k * lw));
            end
        end else begin
            e = 1'b1;
        end
    endfunction

    // Runs one full transaction: offer, accept, wait for the result with
    // junk on the inputs, hold backpressure, then consume while a new request
    // is offered (which must not be taken).
    task automatic applyStimulus(input logic [5:0] op, input logic [1:0] w,
                                 input logic [63:0] a, input logic [63:0] b, input int hold,
                                 output logic [63:0] d, output logic e, output int lat);
        logic [63:0] held_d;
        logic        held_e;
        logic        busy_ok;
        @(negedge clk);
        checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
        alu_op    = op;
        ww        = w;
        opr_a     = a;
        opr_b     = b;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        alu_op  = 6'($urandom);
        ww      = 2'($urandom);
        opr_a   = {$urandom, $urandom};
        opr_b   = {$urandom, $urandom};
        lat     = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("in_ready_busy", 64'(busy_ok), 64'd1);
        d = dout;
        e = err;
        if (!out_valid) begin
            checkOutput("out_valid_timeout", 64'(out_valid), 64'd1);
            in_valid = 1'b0;
            return;
        end
        checkOutput("in_ready_done", 64'(in_ready), 64'd0);
        held_d   = dout;
        held_e   = err;
        alu_op   = OP_ADD;
        in_valid = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid", 64'(out_valid), 64'd1);
            checkOutput("bp_dout", dout, held_d);
            checkOutput("bp_err", 64'(err), 64'(held_e));
            checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkOutput("consumed", 64'(out_valid), 64'd0);
        checkOutput("no_accept_on_consume", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [63:0] ed;
        logic        e;
        logic        ee;
        int          lat;
        int          elat;
        logic [5:0]  op;
        logic [1:0]  w;
        logic [63:0] a;
        logic [63:0] b;
        logic        saw_valid;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = '0;
        ww        = '0;
        opr_a     = '0;
        opr_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_dout", dout, 64'd0);
        checkOutput("reset_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed results.
        applyStimulus(OP_ADD, 2'b00, 64'h00FF_0001_7FFF_FFFF, 64'h0001_0001_0001_0001, 0, d, e, lat);
        checkOutput("add_b_dout", d, 64'h0000_0002_7F00_FF00);
        checkOutput("add_b_err", 64'(e), 64'd0);
        checkOutput("add_b_lat", 64'(lat), 64'd1);

        applyStimulus(OP_ADD, 2'b11, 64'h00FF_0001_7FFF_FFFF, 64'h0001_0001_0001_0001, 1, d, e, lat);
        checkOutput("add_d_dout", d, 64'h0100_0002_8001_0000);
        checkOutput("add_d_lat", 64'(lat), 64'd1);

        applyStimulus(OP_SUB, 2'b01, 64'h0000_0005_8000_FFFF, 64'h0001_0003_0001_FFFF, 0, d, e, lat);
        checkOutput("sub_h_dout", d, 64'hFFFF_0002_7FFF_0000);
        checkOutput("sub_h_err", 64'(e), 64'd0);

        applyStimulus(OP_MULE, 2'b00, 64'h0003_00FF_0010_0002, 64'h0005_00FF_0010_0080, 5, d, e, lat);
        checkOutput("mule_b_dout", d, 64'h000F_FE01_0100_0100);
        checkOutput("mule_b_lat", 64'(lat), 64'd9);

        applyStimulus(OP_MULO, 2'b10, 64'hFFFF_FFFF_1234_5678, 64'h0000_0002_DEAD_BEEF, 0, d, e, lat);
        checkOutput("mulo_w_dout", d, 64'h0000_0001_FFFF_FFFE);
        checkOutput("mulo_w_lat", 64'(lat), 64'd33);

        applyStimulus(6'b111111, 2'b00, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 0, d, e, lat);
        checkOutput("illegal_op_dout", d, 64'd0);
        checkOutput("illegal_op_err", 64'(e), 64'd1);
        checkOutput("illegal_op_lat", 64'(lat), 64'd1);

        applyStimulus(OP_MULE, 2'b11, 64'h0003_00FF_0010_0002, 64'h0005_00FF_0010_0080, 2, d, e, lat);
        checkOutput("mule_d_dout", d, 64'd0);
        checkOutput("mule_d_err", 64'(e), 64'd1);
        checkOutput("mule_d_lat", 64'(lat), 64'd1);

        // Reset during a halfword multiply discards the partial result.
        @(negedge clk);
        alu_op   = OP_MULE;
        ww       = 2'b01;
        opr_a    = 64'hFFFF_FFFF_FFFF_FFFF;
        opr_b    = 64'hFFFF_FFFF_FFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_dout", dout, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        saw_valid = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("midrst_no_result", 64'(saw_valid), 64'd0);
        checkOutput("midrst_idle", 64'(in_ready), 64'd1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0:       op = OP_ADD;
                1:       op = OP_SUB;
                2:       op = OP_MULE;
                3:       op = OP_MULO;
                default: op = 6'($urandom);
            endcase
            w = 2'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            refModel(op, w, a, b, ed, ee, elat);
            applyStimulus(op, w, a, b, $urandom_range(0, 2), d, e, lat);
            checkOutput($sformatf("rand%0d_dout", i), d, ed);
            checkOutput($sformatf("rand%0d_err", i), 64'(e), 64'(ee));
            checkOutput($sformatf("rand%0d_lat", i), 64'(lat), 64'(elat));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
